// File: rtl/binary_xnor_popcount_linear_if.sv
// Stream bundle for the binary XNOR-popcount linear layer: activation, weight and bias
// inputs plus the result output, each with its own valid/ready pair.
interface binary_xnor_popcount_linear_if #(
    parameter int IN_SIZE     = 4,
    parameter int PARALLELISM = 2,
    parameter int BIAS_WIDTH  = 8,
    parameter int OUT_WIDTH   = 5
);
    logic [IN_SIZE-1:0]                         data_in;
    logic                                       data_in_valid;
    logic                                       data_in_ready;
    logic [IN_SIZE*PARALLELISM-1:0]             weight;
    logic                                       weight_valid;
    logic                                       weight_ready;
    logic [PARALLELISM-1:0][BIAS_WIDTH-1:0]     bias;
    logic                                       bias_valid;
    logic                                       bias_ready;
    logic [PARALLELISM-1:0][OUT_WIDTH-1:0]      data_out;
    logic                                       data_out_valid;
    logic                                       data_out_ready;

    modport master (
        output data_in, data_in_valid, weight, weight_valid, bias, bias_valid, data_out_ready,
        input  data_in_ready, weight_ready, bias_ready, data_out, data_out_valid
    );

    modport slave (
        input  data_in, data_in_valid, weight, weight_valid, bias, bias_valid, data_out_ready,
        output data_in_ready, weight_ready, bias_ready, data_out, data_out_valid
    );
endinterface

// File: rtl/binary_xnor_popcount_linear.sv
// Streaming fully-binary linear layer: per-channel XNOR-popcount accumulated over
// IN_DEPTH beats, optional saturating bias, optional sign re-binarisation.
module binary_xnor_popcount_linear #(
    parameter int IN_SIZE     = 4,
    parameter int IN_DEPTH    = 3,
    parameter int PARALLELISM = 2,
    parameter int HAS_BIAS    = 0,
    parameter int BIAS_WIDTH  = 8,
    parameter int OUTPUT_MODE = 0,
    parameter int ACC_WIDTH   = $clog2(IN_SIZE*IN_DEPTH+1)+1,
    parameter int OUT_WIDTH   = ACC_WIDTH+HAS_BIAS
) (
    input logic clk,
    input logic rst,
    binary_xnor_popcount_linear_if.slave bus
);
    localparam int SUM_WIDTH = ((ACC_WIDTH > BIAS_WIDTH) ? ACC_WIDTH : BIAS_WIDTH) + 1;
    localparam int CNT_WIDTH = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(IN_DEPTH-1);
    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'((2 ** (OUT_WIDTH-1)) - 1);
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = SUM_WIDTH'(-(2 ** (OUT_WIDTH-1)));

    logic [CNT_WIDTH-1:0]                  beat_cnt;
    logic                                  last_beat;
    logic                                  can_accept;
    logic                                  fire;
    logic                                  out_load;
    logic                                  out_valid;
    logic [PARALLELISM-1:0][OUT_WIDTH-1:0] result;
    logic [PARALLELISM-1:0][OUT_WIDTH-1:0] out_q;

    // Only the closing beat needs a free output slot and a bias word; earlier beats
    // keep accumulating the next vector while a finished result is stalled.
    assign last_beat  = (beat_cnt == LAST_CNT);
    assign can_accept = !last_beat ||
                        ((!out_valid || bus.data_out_ready) && (bus.bias_valid || (HAS_BIAS == 0)));
    assign fire       = bus.data_in_valid && bus.weight_valid && can_accept;
    assign out_load   = fire && last_beat;

    assign bus.data_in_ready  = fire;
    assign bus.weight_ready   = fire;
    assign bus.bias_ready     = (HAS_BIAS != 0) ? out_load : 1'b1;
    assign bus.data_out       = out_q;
    assign bus.data_out_valid = out_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
        end else if (fire) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < PARALLELISM; i++) begin : g_ch
        logic [IN_SIZE-1:0]          match;
        logic [ACC_WIDTH-1:0]        ones;
        logic signed [ACC_WIDTH-1:0] term;
        logic signed [ACC_WIDTH-1:0] acc;
        logic signed [ACC_WIDTH-1:0] acc_next;
        logic signed [SUM_WIDTH-1:0] bias_ext;
        logic signed [SUM_WIDTH-1:0] sum;
        logic [OUT_WIDTH-1:0]        chan_result;

        assign match = ~(bus.data_in ^ bus.weight[IN_SIZE*i +: IN_SIZE]);

        always_comb begin
            ones = '0;
            for (int j = 0; j < IN_SIZE; j++) begin
                ones = ones + ACC_WIDTH'(match[j]);
            end
        end

        // matches - mismatches == 2*matches - IN_SIZE, kept modulo ACC_WIDTH as two's complement
        assign term     = (ones << 1) - ACC_WIDTH'(IN_SIZE);
        assign acc_next = acc + term;
        assign bias_ext = (HAS_BIAS != 0) ?
                          {{(SUM_WIDTH-BIAS_WIDTH){bus.bias[i][BIAS_WIDTH-1]}}, bus.bias[i]} : '0;
        assign sum      = {{(SUM_WIDTH-ACC_WIDTH){acc_next[ACC_WIDTH-1]}}, acc_next} + bias_ext;

        always_comb begin
            chan_result = sum[OUT_WIDTH-1:0];
            if (sum > SAT_MAX) begin
                chan_result = SAT_MAX[OUT_WIDTH-1:0];
            end else if (sum < SAT_MIN) begin
                chan_result = SAT_MIN[OUT_WIDTH-1:0];
            end
            if (OUTPUT_MODE != 0) begin
                chan_result    = '0;
                chan_result[0] = !sum[SUM_WIDTH-1];
            end
        end

        assign result[i] = chan_result;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc <= '0;
            end else if (fire) begin
                acc <= last_beat ? '0 : acc_next;
            end
        end
    end

    // A new result may load in the same cycle the old one is accepted, so valid stays high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (out_load) begin
            out_valid <= 1'b1;
            out_q     <= result;
        end else if (bus.data_out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/binary_xnor_popcount_linear.md
Name: binary_xnor_popcount_linear

Overview:
Streaming fully-binary linear layer. Activations and weights are 1-bit, encoded as 1 = +1 and 0 = -1. Each output channel computes an XNOR-popcount dot product over IN_SIZE lanes and accumulates it across IN_DEPTH beats. The block adds an optional saturating bias and optionally re-binarises the result with a sign function. This lets binary layers chain directly without an external activation block.

Parameters:
IN_SIZE, 4, activation lanes per beat
IN_DEPTH, 3, beats per input vector (>=1)
PARALLELISM, 2, output channels computed in parallel
HAS_BIAS, 0, 1 = add per-channel signed bias on the last beat
BIAS_WIDTH, 8, signed bias width
OUTPUT_MODE, 0, 0 = signed integer sum; 1 = sign-binarised (1 if sum >= 0, else 0)
ACC_WIDTH, $clog2(IN_SIZE*IN_DEPTH+1)+1, signed accumulator width (derived)
OUT_WIDTH, ACC_WIDTH+HAS_BIAS, output word width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
data_in  in  [IN_SIZE] x 1  activation bits for one beat
data_in_valid  in  1  activation beat valid
data_in_ready  out  1  activation beat accepted
weight  in  [IN_SIZE*PARALLELISM] x 1  weights; channel i uses lanes [IN_SIZE*i +: IN_SIZE]
weight_valid  in  1  weight beat valid
weight_ready  out  1  weight beat accepted
bias  in  [PARALLELISM] x BIAS_WIDTH  signed bias per channel
bias_valid  in  1  bias valid
bias_ready  out  1  bias consumed
data_out  out  [PARALLELISM] x OUT_WIDTH  result per channel
data_out_valid  out  1  result valid
data_out_ready  in  1  downstream accept

Behaviour:
- Reset (rst=0, async): beat_cnt=0, all accumulators=0, data_out_valid=0, data_out=0. A partially accumulated vector is discarded.
- Beat acceptance (fire): data_in_valid & weight_valid & can_accept. On fire, data_in_ready and weight_ready are both 1 in the same cycle. Neither side is consumed without the other.
- last_beat = (beat_cnt == IN_DEPTH-1).
- can_accept = !last_beat | ((!data_out_valid | data_out_ready) & (bias_valid | !HAS_BIAS)).
  - Non-last beats are never blocked by output backpressure. This allows the next vector to accumulate while a result is stalled.
- Per-beat channel term: 2*popcount(~(data_in ^ w_i)) - IN_SIZE, signed, in the range [-IN_SIZE, IN_SIZE].
- On a fire that is not the last beat: acc_i += term; beat_cnt++.
- On a last-beat fire:
  - sum_i = acc_i + term (+ sign-extended bias_i if HAS_BIAS).
  - The output register loads; acc_i is cleared to 0; beat_cnt wraps to 0.
  - data_out_valid = 1 on the next cycle. Latency is 1 cycle from the last-beat fire.
- Bias: bias_ready = last-beat fire (a single-cycle pulse) when HAS_BIAS=1. When HAS_BIAS=0, bias_ready is tied to 1 and bias is ignored.
- Width and saturation:
  - Sum is computed at max(ACC_WIDTH, BIAS_WIDTH)+1 bits, then saturated to the signed OUT_WIDTH range.
  - Clamp to 2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1). No wrap.
- OUTPUT_MODE=1: data_out[i][0] = (sum_i >= 0); upper bits = 0. A sum of exactly 0 maps to 1 (+1).
- Output register:
  - Holds data_out stable while data_out_valid & !data_out_ready.
  - Clears valid on accept unless a last-beat fire occurs in the same cycle. In that case the new result loads and valid stays 1, giving full throughput.
- IN_DEPTH=1: every beat is a last beat. Throughput is 1 vector per cycle when unstalled.
- All channels share one counter and one handshake, so they are always in lockstep.

Test Plan:
1. Defaults. 3 beats, data=1111, weights all 1 on both channels → data_out = {12, 12}, data_out_valid rises 1 cycle after the 3rd fire.
2. Channel 1 weights = 0000 every beat, channel 0 weights = data → {12, -12}. Alternate-lane mismatch (2 of 4 lanes match per beat) → 0.
3. HAS_BIAS=1, BIAS_WIDTH=8 (OUT_WIDTH=6), half-match sum 0:
   - bias = -5 → -5; bias_ready pulses once, on the 3rd beat only.
   - sum 12 with bias 127 → saturates to 31.
   - sum -12 with bias -128 → saturates to -32.
4. Backpressure. Result pending with data_out_ready=0: next vector beats 0 and 1 fire; beat 2 sees data_in_ready=0 for 4 cycles. Raising data_out_ready → beat 2 fires in that same cycle, the old result is accepted, the new result is valid next cycle, and data_out is unchanged while stalled.
5. OUTPUT_MODE=1: sum 0 → data_out[i]=1; sum -2 → 0; sum 12 → 1.
6. Assert rst=0 mid-vector after 2 beats, then release and send a fresh 3-beat all-match vector → 12, with no residue from the aborted vector and data_out_valid=0 throughout reset.
